fft_bfly_sched: RTL and testbench

- Sequencer for one shared radix-2 DIT butterfly (combinational, packed {Re,Im} Q1.15, 32 bit) performing an in-place N-point FFT on a single dual-port sample RAM.
- Each cycle it issues one butterfly: the two read addresses and the twiddle ROM address.
- One cycle later it issues the matching write-back addresses, with the butterfly's sum written to A and diff written to B.
- Samples are preloaded into the RAM in bit-reversed order by the capture logic before start.

---
 rtl/fft_bfly_sched.sv | 122 ++++++++++++
 tb/tb_fft_bfly_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_sched.sv
// Address/strobe sequencer for one shared radix-2 DIT butterfly running an
// in-place N-point FFT on a dual-port RAM preloaded in bit-reversed order.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// RUN   | one butterfly read per cycle unless hold, j counts 0..N/2-1
// DRAIN | one read-free cycle so the stage's last write retires first
// FIN   | one-cycle done pulse, then IDLE
module fft_bfly_sched #(
  parameter int N     = 8,
  parameter int LOG2N = $clog2(N),
  parameter int TW_AW = LOG2N - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [TW_AW-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [LOG2N-1:0] stage
);

  localparam int JW = LOG2N - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state, state_nxt;
  logic [LOG2N-1:0] s, s_nxt;
  logic [JW-1:0]    j, j_nxt;

  logic [LOG2N-1:0] half, pos, grp, calc_a, calc_b;
  logic [TW_AW-1:0] calc_tw;
  logic [LOG2N-1:0] rd_a_q, rd_b_q;
  logic [TW_AW-1:0] tw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      j         <= '0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      tw_q      <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      j     <= j_nxt;
      wr_en <= rd_en;
      if (rd_en) begin
        rd_a_q    <= calc_a;
        rd_b_q    <= calc_b;
        tw_q      <= calc_tw;
        wr_addr_a <= calc_a;
        wr_addr_b <= calc_b;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    j_nxt     = j;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          j_nxt     = '0;
        end
      end
      RUN: begin
        if (!hold) begin
          j_nxt = j + JW'(1);
          if (&j) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (s < LOG2N'(LOG2N - 1)) begin
          s_nxt     = s + LOG2N'(1);
          j_nxt     = '0;
          state_nxt = RUN;
        end else begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        s_nxt     = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly index split: pos within the group selects the twiddle, grp the span.
  always_comb begin
    half    = LOG2N'(1) << s;
    pos     = LOG2N'(j) & (half - LOG2N'(1));
    grp     = LOG2N'(j) >> s;
    calc_a  = (grp << (s + LOG2N'(1))) | pos;
    calc_b  = calc_a + half;
    calc_tw = TW_AW'(pos << (LOG2N'(LOG2N - 1) - s));
  end

  assign rd_en     = (state == RUN) && !hold && !rst;
  assign rd_addr_a = rd_en ? calc_a  : rd_a_q;
  assign rd_addr_b = rd_en ? calc_b  : rd_b_q;
  assign tw_addr   = rd_en ? calc_tw : tw_q;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == FIN);
  assign stage     = busy ? s : '0;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench: N=8 schedule/hold/reset/start checks and an N=16 FFT run
// through a behavioural RAM, twiddle ROM and butterfly.
module tb_fft_bfly_sched;

  logic       clk;
  logic       rst;
  logic       start, hold;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [1:0] tw_addr;

  logic       g_start, g_hold;
  logic       g_busy, g_done, g_rd_en, g_wr_en;
  logic [3:0] g_rd_addr_a, g_rd_addr_b, g_wr_addr_a, g_wr_addr_b, g_stage;
  logic [2:0] g_tw_addr;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] ea [12];
  logic [2:0] eb [12];
  logic [1:0] et [12];

  fft_bfly_sched #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
  );

  fft_bfly_sched #(.N(16)) gdut (
    .clk(clk), .rst(rst), .start(g_start), .hold(g_hold),
    .busy(g_busy), .done(g_done), .rd_en(g_rd_en),
    .rd_addr_a(g_rd_addr_a), .rd_addr_b(g_rd_addr_b), .tw_addr(g_tw_addr),
    .wr_en(g_wr_en), .wr_addr_a(g_wr_addr_a), .wr_addr_b(g_wr_addr_b), .stage(g_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sample RAM, twiddle ROM and butterfly for the N=16 instance.
  logic signed [15:0] mem_re [16];
  logic signed [15:0] mem_im [16];
  logic signed [15:0] rom_re [8];
  logic signed [15:0] rom_im [8];
  logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [15:0] s_re, s_im, d_re, d_im;
  int                 t_re, t_im;
  logic               g_ld_en;
  logic [3:0]         g_ld_addr;
  logic signed [15:0] g_ld_re, g_ld_im;

  always @(posedge clk) begin
    if (g_rd_en) begin
      a_re <= mem_re[g_rd_addr_a];
      a_im <= mem_im[g_rd_addr_a];
      b_re <= mem_re[g_rd_addr_b];
      b_im <= mem_im[g_rd_addr_b];
      w_re <= rom_re[g_tw_addr];
      w_im <= rom_im[g_tw_addr];
    end
    if (g_wr_en) begin
      mem_re[g_wr_addr_a] <= s_re;
      mem_im[g_wr_addr_a] <= s_im;
      mem_re[g_wr_addr_b] <= d_re;
      mem_im[g_wr_addr_b] <= d_im;
    end
    if (g_ld_en) begin
      mem_re[g_ld_addr] <= g_ld_re;
      mem_im[g_ld_addr] <= g_ld_im;
    end
  end

  always_comb begin
    t_re = (int'(b_re) * int'(w_re) - int'(b_im) * int'(w_im)) >>> 15;
    t_im = (int'(b_re) * int'(w_im) + int'(b_im) * int'(w_re)) >>> 15;
    s_re = 16'(int'(a_re) + t_re);
    s_im = 16'(int'(a_im) + t_im);
    d_re = 16'(int'(a_re) - t_re);
    d_im = 16'(int'(a_im) - t_im);
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    n_assert++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int bitrev4(input int n);
    int r = 0;
    for (int i = 0; i < 4; i++) if (n[i]) r |= 1 << (3 - i);
    return r;
  endfunction

  // Full N=8 transform; e is the hold-free schedule cycle (RUN at e%5!=0, e<=15;
  // done at e==16). hs/hl place a hold window, sp1/sp2 extra start pulses.
  task automatic run_sched(input string tag, input int hs, input int hl,
                           input int sp1, input int sp2);
    int         e, ri, n_rd, n_wr, n_done;
    logic       prev_rd, exp_rd, run_ph, hold_now;
    logic [2:0] pa, pb;
    start = 1'b1;
    hold  = 1'b0;
    #1;
    chk($sformatf("%s start busy", tag), busy, 0);
    next();
    e = 1; ri = 0; n_rd = 0; n_wr = 0; n_done = 0; prev_rd = 1'b0; pa = '0; pb = '0;
    for (int c = 1; c <= 17 + hl; c++) begin
      hold_now = (c >= hs) && (c < hs + hl);
      hold     = hold_now;
      start    = (c == sp1) || (c == sp2);
      #1;
      run_ph = (e <= 15) && (e % 5 != 0);
      exp_rd = run_ph && !hold_now;
      if (rd_en === 1'b1) n_rd++;
      if (wr_en === 1'b1) n_wr++;
      if (done === 1'b1) n_done++;
      chk($sformatf("%s c%0d rd_en", tag, c), rd_en, exp_rd);
      if (exp_rd) begin
        chk($sformatf("%s c%0d rd_a", tag, c), rd_addr_a, ea[ri]);
        chk($sformatf("%s c%0d rd_b", tag, c), rd_addr_b, eb[ri]);
        chk($sformatf("%s c%0d tw", tag, c), tw_addr, et[ri]);
      end
      chk($sformatf("%s c%0d wr_en", tag, c), wr_en, prev_rd);
      if (prev_rd) begin
        chk($sformatf("%s c%0d wr_a", tag, c), wr_addr_a, pa);
        chk($sformatf("%s c%0d wr_b", tag, c), wr_addr_b, pb);
      end
      chk($sformatf("%s c%0d busy", tag, c), busy, (e >= 1 && e <= 15));
      chk($sformatf("%s c%0d done", tag, c), done, (e == 16));
      if (e <= 15) chk($sformatf("%s c%0d stage", tag, c), stage, (e - 1) / 5);
      else if (e >= 17) chk($sformatf("%s c%0d stage", tag, c), stage, 0);
      prev_rd = exp_rd;
      if (exp_rd) begin
        pa = ea[ri];
        pb = eb[ri];
        ri++;
      end
      if (!(run_ph && hold_now)) e++;
      next();
    end
    start = 1'b0;
    hold  = 1'b0;
    #1;
    chk($sformatf("%s after busy", tag), busy, 0);
    chk($sformatf("%s rd count", tag), n_rd, 12);
    chk($sformatf("%s wr count", tag), n_wr, 12);
    chk($sformatf("%s done count", tag), n_done, 1);
    next();
  endtask

  task automatic load(input int addr, input int re, input int im);
    g_ld_en   = 1'b1;
    g_ld_addr = 4'(addr);
    g_ld_re   = 16'(re);
    g_ld_im   = 16'(im);
    next();
    g_ld_en = 1'b0;
  endtask

  task automatic run_golden(input string tag);
    int   cnt;
    logic seen;
    g_start = 1'b1;
    next();
    g_start = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      #1;
      if (g_busy === 1'b1) cnt++;
      if (g_done === 1'b1) seen = 1'b1;
      else next();
    end
    chk($sformatf("%s done seen", tag), seen, 1);
    chk($sformatf("%s busy cycles", tag), cnt, 36);
    next();
    #1;
    chk($sformatf("%s stage idle", tag), g_stage, 0);
  endtask

  int xv;

  initial begin
    ea = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    eb = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    et = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 8; k++) begin
      rom_re[k] = 16'(rnd(32767.0 * $cos(2.0 * 3.14159265358979 * k / 16.0)));
      rom_im[k] = 16'(rnd(-32767.0 * $sin(2.0 * 3.14159265358979 * k / 16.0)));
    end
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    g_start = 1'b0; g_hold = 1'b0; g_ld_en = 1'b0; g_ld_addr = '0; g_ld_re = '0; g_ld_im = '0;
    next();
    next();
    rst = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset rd_en", rd_en, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset rd_a", rd_addr_a, 0);
    chk("reset rd_b", rd_addr_b, 0);
    chk("reset tw", tw_addr, 0);
    chk("reset wr_a", wr_addr_a, 0);
    chk("reset wr_b", wr_addr_b, 0);
    chk("reset stage", stage, 0);
    next();

    run_sched("base", 0, 0, 0, 0);
    run_sched("hold", 8, 3, 0, 0);

    // Abort in stage 1: cycle 7 issues (1,3) whose write must be dropped.
    start = 1'b1;
    next();
    start = 1'b0;
    repeat (6) next();
    #1;
    chk("abort pre rd_en", rd_en, 1);
    chk("abort pre stage", stage, 1);
    rst = 1'b1;
    next();
    rst = 1'b0;
    #1;
    chk("abort wr_en", wr_en, 0);
    chk("abort rd_en", rd_en, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort stage", stage, 0);
    chk("abort rd_a", rd_addr_a, 0);
    chk("abort rd_b", rd_addr_b, 0);
    chk("abort tw", tw_addr, 0);
    chk("abort wr_a", wr_addr_a, 0);
    chk("abort wr_b", wr_addr_b, 0);
    next();
    run_sched("replay", 0, 0, 0, 0);
    run_sched("startign", 0, 0, 3, 16);

    // Impulse: every bin equals the input sample.
    for (int n = 0; n < 16; n++) load(bitrev4(n), (n == 0) ? 10000 : 0, 0);
    run_golden("impulse");
    for (int k = 0; k < 16; k++) begin
      chk_tol($sformatf("impulse re[%0d]", k), int'(mem_re[k]), 10000, 4);
      chk_tol($sformatf("impulse im[%0d]", k), int'(mem_im[k]), 0, 4);
    end

    // Cosine at bin 2, amplitude 2048: peaks of 16*2048/2 at bins 2 and 14.
    for (int n = 0; n < 16; n++) begin
      xv = rnd(2048.0 * $cos(2.0 * 3.14159265358979 * 2.0 * n / 16.0));
      load(bitrev4(n), xv, 0);
    end
    run_golden("cosine");
    for (int k = 0; k < 16; k++) begin
      chk_tol($sformatf("cosine re[%0d]", k), int'(mem_re[k]),
              (k == 2 || k == 14) ? 16384 : 0, 48);
      chk_tol($sformatf("cosine im[%0d]", k), int'(mem_im[k]), 0, 48);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
